// File: rtl/mips_mem_pkg.sv
// Shared opcode, FSM-state and lane constants for the MEM-stage access unit.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (size)
      SZ_BYTE: data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{16{is_signed & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack transaction per aligned memory op,
// stalling the pipeline until completion.
module mem_access_unit
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] ALUOUT_M,
  input  logic [31:0] RT_M,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic [31:0] ld_data,
  output logic        adel,
  output logic        ades
);

  state_t      state;
  logic [5:0]  op;
  logic        is_load;
  logic        is_store;
  logic [1:0]  size;
  logic        sgn;
  logic        misaligned;
  logic        go;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_sgn;
  logic [31:0] aligned;
  logic        unused_ir;

  assign op        = IR_M[31:26];
  assign unused_ir = ^IR_M[25:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_WORD;
    sgn      = 1'b0;
    case (op)
      OP_LB:   begin is_load  = 1'b1; size = SZ_BYTE; sgn = 1'b1; end
      OP_LH:   begin is_load  = 1'b1; size = SZ_HALF; sgn = 1'b1; end
      OP_LW:   begin is_load  = 1'b1; size = SZ_WORD; end
      OP_LBU:  begin is_load  = 1'b1; size = SZ_BYTE; end
      OP_LHU:  begin is_load  = 1'b1; size = SZ_HALF; end
      OP_SB:   begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:   begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:   begin is_store = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (size == SZ_WORD)      misaligned = (ALUOUT_M[1:0] != 2'b00);
    else if (size == SZ_HALF) misaligned = ALUOUT_M[0];
  end

  assign adel      = is_load  & misaligned;
  assign ades      = is_store & misaligned;
  assign go        = (is_load | is_store) & ~misaligned;
  assign dm_req    = (state == ST_WAIT);
  assign mem_stall = ((state == ST_IDLE) & go) | (state == ST_WAIT);

  // Loads always read the full word; extraction happens on the return path.
  always_comb begin
    be_n    = BE_ALL;
    wdata_n = '0;
    if (is_store) begin
      case (size)
        SZ_BYTE: begin
          be_n    = BE_BYTE0 << ALUOUT_M[1:0];
          wdata_n = {4{RT_M[7:0]}};
        end
        SZ_HALF: begin
          be_n    = ALUOUT_M[1] ? BE_HI_HALF : BE_LO_HALF;
          wdata_n = {2{RT_M[15:0]}};
        end
        default: begin
          be_n    = BE_ALL;
          wdata_n = RT_M;
        end
      endcase
    end
  end

  load_align u_load_align (
    .rdata     (dm_rdata),
    .offset    (ld_off),
    .size      (ld_size),
    .is_signed (ld_sgn),
    .data      (aligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      dm_we    <= 1'b0;
      dm_be    <= '0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      ld_data  <= '0;
      ld_off   <= '0;
      ld_size  <= '0;
      ld_sgn   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            state    <= ST_WAIT;
            dm_addr  <= {ALUOUT_M[31:2], 2'b00};
            dm_we    <= is_store;
            dm_be    <= be_n;
            dm_wdata <= wdata_n;
            ld_off   <= ALUOUT_M[1:0];
            ld_size  <= size;
            ld_sgn   <= sgn;
          end
        end
        ST_WAIT: begin
          if (dm_ack) begin
            state <= ST_DONE;
            if (!dm_we) ld_data <= aligned;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against an arithmetic reference model.
module tb_mem_access_unit;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  logic        clk;
  logic        reset;
  logic [31:0] IR_M;
  logic [31:0] ALUOUT_M;
  logic [31:0] RT_M;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_stall;
  logic [31:0] ld_data;
  logic        adel;
  logic        ades;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] model_ld = '0;
  int unsigned total_req = 0;

  mem_access_unit dut (
    .clk       (clk),
    .reset     (reset),
    .IR_M      (IR_M),
    .ALUOUT_M  (ALUOUT_M),
    .RT_M      (RT_M),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_be     (dm_be),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .mem_stall (mem_stall),
    .ld_data   (ld_data),
    .adel      (adel),
    .ades      (ades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_load(input logic [5:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU;
  endfunction

  function automatic bit m_is_store(input logic [5:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] a);
    if (op == LW || op == SW) return (a % 4) != 0;
    if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
    int unsigned k = a % 4;
    if (op == SB) return 4'(1 << k);
    if (op == SH) return (k >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] rt);
    if (op == SB) return (rt & 32'hFF) * 32'h0101_0101;
    if (op == SH) return (rt & 32'hFFFF) * 32'h0001_0001;
    return rt;
  endfunction

  function automatic logic [31:0] m_ld(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
    int unsigned k = a % 4;
    logic [31:0] v;
    if (op == LB || op == LBU) begin
      v = (rd >> (8 * k)) & 32'hFF;
      if (op == LB && v >= 32'h80) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (op == LH || op == LHU) begin
      v = (rd >> (16 * (k / 2))) & 32'hFFFF;
      if (op == LH && v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  task automatic set_ir(input logic [5:0] op);
    logic [31:0] r;
    r = $urandom;
    IR_M = {op, r[25:0]};
  endtask

  task automatic access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rdata, input int unsigned nwait);
    int unsigned nstall;
    int unsigned nreq;
    @(posedge clk); #1;
    set_ir(op);
    ALUOUT_M = addr;
    RT_M     = rt;
    dm_ack   = 1'b0;
    dm_rdata = $urandom;
    #1;
    nstall = mem_stall;
    nreq   = dm_req;
    chk("idle_adel", 32'(adel), 32'd0);
    chk("idle_ades", 32'(ades), 32'd0);
    for (int unsigned i = 0; i <= nwait; i++) begin
      @(posedge clk); #1;
      if (i == nwait) begin
        dm_ack   = 1'b1;
        dm_rdata = rdata;
      end
      #1;
      nstall += mem_stall;
      nreq   += dm_req;
      chk("wait_addr", dm_addr, addr & 32'hFFFF_FFFC);
      chk("wait_we", 32'(dm_we), 32'(m_is_store(op)));
      chk("wait_be", 32'(dm_be), 32'(m_be(op, addr)));
      if (m_is_store(op)) chk("wait_wdata", dm_wdata, m_wdata(op, rt));
    end
    @(posedge clk); #1;
    dm_ack   = 1'b0;
    dm_rdata = $urandom;
    IR_M     = '0;
    #1;
    if (m_is_load(op)) model_ld = m_ld(op, addr, rdata);
    total_req += nreq;
    chk("done_req", 32'(dm_req), 32'd0);
    chk("done_stall", 32'(mem_stall), 32'd0);
    chk("done_ld_data", ld_data, model_ld);
    chk("stall_cycles", nstall, nwait + 2);
    chk("req_cycles", nreq, nwait + 1);
  endtask

  task automatic no_access(input logic [31:0] ir, input logic [31:0] addr);
    @(posedge clk); #1;
    IR_M     = ir;
    ALUOUT_M = addr;
    dm_ack   = 1'b0;
    #1;
    chk("na_adel", 32'(adel), 32'(m_is_load(ir[31:26]) && m_misaligned(ir[31:26], addr)));
    chk("na_ades", 32'(ades), 32'(m_is_store(ir[31:26]) && m_misaligned(ir[31:26], addr)));
    for (int unsigned i = 0; i < 3; i++) begin
      chk("na_req", 32'(dm_req), 32'd0);
      chk("na_stall", 32'(mem_stall), 32'd0);
      @(posedge clk); #2;
    end
    chk("na_ld_data", ld_data, model_ld);
    IR_M = '0;
  endtask

  initial begin
    logic [5:0]  ops [9];
    logic [5:0]  op;
    logic [31:0] addr;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'b000000};

    reset = 1'b0; IR_M = '0; ALUOUT_M = '0; RT_M = '0; dm_rdata = '0; dm_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_we", 32'(dm_we), 32'd0);
    chk("rst_be", 32'(dm_be), 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    reset = 1'b1;

    // Reset pulse while a load is outstanding; the late ack must be ignored.
    @(posedge clk); #1;
    set_ir(LW); ALUOUT_M = 32'h300;
    @(posedge clk); #2;
    chk("rw_req_up", 32'(dm_req), 32'd1);
    reset = 1'b0;
    IR_M  = '0;
    #1;
    chk("rw_req_drop", 32'(dm_req), 32'd0);
    chk("rw_stall_drop", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    #1;
    chk("rw_late_req", 32'(dm_req), 32'd0);
    chk("rw_late_ld", ld_data, 32'd0);
    chk("rw_late_stall", 32'(mem_stall), 32'd0);

    access(LW,  32'h100, 32'h0, 32'hDEAD_BEEF, 1);
    chk("lw_result", ld_data, 32'hDEAD_BEEF);
    access(LB,  32'h103, 32'h0, 32'h8012_3456, 0);
    chk("lb_result", ld_data, 32'hFFFF_FF80);
    access(LBU, 32'h103, 32'h0, 32'h8012_3456, 0);
    chk("lbu_result", ld_data, 32'h0000_0080);
    access(LH,  32'h102, 32'h0, 32'h8012_3456, 2);
    chk("lh_result", ld_data, 32'hFFFF_8012);
    access(SB,  32'h201, 32'h0000_00A5, 32'h0, 0);
    access(SH,  32'h202, 32'h0000_1234, 32'h0, 1);
    chk("st_ld_kept", ld_data, 32'hFFFF_8012);

    no_access({LW, 26'h0}, 32'h102);
    no_access({SH, 26'h0}, 32'h201);

    total_req = 0;
    access(LW, 32'h400, 32'h0, 32'hCAFE_F00D, 0);
    access(SW, 32'h404, 32'h5555_AAAA, 32'h0, 0);
    no_access(32'h0, 32'h0);
    chk("b2b_requests", total_req, 32'd2);

    for (int unsigned n = 0; n < 40; n++) begin
      op   = ops[$urandom_range(8)];
      addr = $urandom;
      if ($urandom_range(3) != 0) begin
        if (op == LW || op == SW) addr[1:0] = 2'b00;
        else if (op == LH || op == LHU || op == SH) addr[0] = 1'b0;
      end
      if (m_is_load(op) || m_is_store(op)) begin
        if (m_misaligned(op, addr)) no_access({op, 26'h155}, addr);
        else access(op, addr, $urandom, $urandom, $urandom_range(3));
      end else begin
        no_access(32'h0, addr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
